// File: rtl/mul_load_pkg.sv
// Shared definitions for the multiplier register-file load path.
package mul_load_pkg;

    // Pairs per burst; equals the register-file slot count.
    localparam int NBEAT_DEF = 3;
    // Default operand width in bits.
    localparam int DATA_DEF  = 256;

    // Load sequencer states, binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WAIT = 3'd2,
        ST_ARM  = 3'd3,
        ST_SEND = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/operand_buf.sv
// Operand pair storage: NBEAT entries of (A, B), indexed write, asynchronous read.
// Storage carries no reset; contents are only meaningful once written.
module operand_buf
    import mul_load_pkg::*;
#(
    parameter int DATA  = DATA_DEF,
    parameter int NBEAT = NBEAT_DEF,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [DATA-1:0]  wr_a,
    input  logic [DATA-1:0]  wr_b,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DATA-1:0]  rd_a,
    output logic [DATA-1:0]  rd_b
);

    logic [DATA-1:0] mem_a [NBEAT];
    logic [DATA-1:0] mem_b [NBEAT];

    // Capture one pair into the addressed slot.
    always_ff @(posedge clk) begin
        if (we && (wr_idx < IDX_W'(NBEAT))) begin
            mem_a[wr_idx] <= wr_a;
            mem_b[wr_idx] <= wr_b;
        end
    end

    // Out-of-range read index (one past the last beat) returns zero.
    assign rd_a = (rd_idx < IDX_W'(NBEAT)) ? mem_a[rd_idx] : '0;
    assign rd_b = (rd_idx < IDX_W'(NBEAT)) ? mem_b[rd_idx] : '0;

endmodule

// File: rtl/operand_burst_tx.sv
// Buffers NBEAT operand pairs and replays them to the multiplier register file
// as a wr_reg strobe followed by NBEAT consecutive beats once the core is idle.
//
// Upstream transfer: a pair moves when in_valid && in_ready at a rising edge;
// in_ready is a register decoded from state, never a function of in_valid, and
// upstream holds in_a/in_b stable while in_valid=1 and in_ready=0.
module operand_burst_tx
    import mul_load_pkg::*;
#(
    parameter int DATA  = DATA_DEF,
    parameter int NBEAT = NBEAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_a,
    input  logic [DATA-1:0] in_b,
    input  logic            flush,
    input  logic            core_idle,
    output logic            wr_reg,
    output logic [DATA-1:0] Output_Data_A,
    output logic [DATA-1:0] Output_Data_B,
    output logic            load_done,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    localparam int CNT_W = $clog2(NBEAT + 1);

    state_t           state;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] rd_idx;
    logic             buf_we;
    logic [DATA-1:0]  rd_a;
    logic [DATA-1:0]  rd_b;

    // A flush in the same cycle drops the handshake.
    assign buf_we = in_valid && in_ready && !flush &&
                    ((state == ST_IDLE) || (state == ST_FILL));

    // Output registers load the beat that will be on the wire next cycle.
    assign rd_idx = (state == ST_SEND) ? beat_cnt + CNT_W'(1) : '0;

    assign dbg_state = state;

    operand_buf #(
        .DATA  (DATA),
        .NBEAT (NBEAT),
        .IDX_W (CNT_W)
    ) u_buf (
        .clk    (clk),
        .we     (buf_we),
        .wr_idx (fill_cnt),
        .wr_a   (in_a),
        .wr_b   (in_b),
        .rd_idx (rd_idx),
        .rd_a   (rd_a),
        .rd_b   (rd_b)
    );

    // Load sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            fill_cnt      <= '0;
            beat_cnt      <= '0;
            in_ready      <= 1'b0;
            wr_reg        <= 1'b0;
            load_done     <= 1'b0;
            busy          <= 1'b0;
            Output_Data_A <= '0;
            Output_Data_B <= '0;
        end else begin
            wr_reg        <= 1'b0;
            load_done     <= 1'b0;
            Output_Data_A <= '0;
            Output_Data_B <= '0;
            case (state)
                ST_IDLE, ST_FILL: begin
                    if (flush) begin
                        state    <= ST_IDLE;
                        fill_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                        busy     <= 1'b1;
                        if (fill_cnt == CNT_W'(NBEAT - 1)) begin
                            state    <= ST_WAIT;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= ST_FILL;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        in_ready <= 1'b1;
                        busy     <= (state != ST_IDLE);
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state    <= ST_IDLE;
                        fill_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (core_idle) begin
                        state  <= ST_ARM;
                        wr_reg <= 1'b1;
                    end
                end
                ST_ARM: begin
                    state         <= ST_SEND;
                    beat_cnt      <= '0;
                    Output_Data_A <= rd_a;
                    Output_Data_B <= rd_b;
                end
                ST_SEND: begin
                    if (beat_cnt == CNT_W'(NBEAT - 1)) begin
                        state     <= ST_DONE;
                        load_done <= 1'b1;
                    end else begin
                        beat_cnt      <= beat_cnt + CNT_W'(1);
                        Output_Data_A <= rd_a;
                        Output_Data_B <= rd_b;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    fill_cnt <= '0;
                    beat_cnt <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    fill_cnt <= '0;
                    beat_cnt <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_burst_tx.sv
// Bench for operand_burst_tx: scenario tasks against a pair-queue reference model.
module tb_operand_burst_tx;
    import mul_load_pkg::*;

    localparam int DATA  = 256;
    localparam int NBEAT = 3;
    localparam int PW    = 2 * DATA;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DATA-1:0] in_a;
    logic [DATA-1:0] in_b;
    logic            flush;
    logic            core_idle;
    logic            wr_reg;
    logic [DATA-1:0] out_a;
    logic [DATA-1:0] out_b;
    logic            load_done;
    logic            busy;
    logic [2:0]      dbg_state;

    // Reference model: pairs accepted and not yet delivered, oldest first.
    logic [PW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    operand_burst_tx #(.DATA(DATA), .NBEAT(NBEAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .flush         (flush),
        .core_idle     (core_idle),
        .wr_reg        (wr_reg),
        .Output_Data_A (out_a),
        .Output_Data_B (out_b),
        .load_done     (load_done),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DATA-1:0] rand_word();
        logic [DATA-1:0] w;
        for (int i = 0; i < DATA / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Advance one cycle; afterwards outputs show the new cycle and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair and hold it until accepted (bounded); model records it.
    task automatic push_pair(input logic [DATA-1:0] a, input logic [DATA-1:0] b);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back({a, b});
        end
        tick();
        in_valid = 1'b0;
        in_a     = rand_word();
        in_b     = rand_word();
    endtask

    // Entered in the cycle after the final handshake; checks the whole burst.
    task automatic check_burst(input string tag, input int hold_busy, input int flush_at);
        logic [PW-1:0]   pair;
        logic [DATA-1:0] ea;
        logic [DATA-1:0] eb;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || wr_reg !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait in_ready=%b busy=%b wr_reg=%b required 0 1 0",
                     tag, in_ready, busy, wr_reg);
        end
        core_idle = 1'b0;
        for (int i = 0; i < hold_busy; i++) begin
            tick();
            checks++;
            if (wr_reg !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_hold%0d wr_reg=%b in_ready=%b busy=%b required 0 0 1",
                         tag, i, wr_reg, in_ready, busy);
            end
        end
        core_idle = 1'b1;
        tick();
        checks++;
        if (wr_reg !== 1'b1 || load_done !== 1'b0 || out_a !== '0 || out_b !== '0) begin
            errors++;
            $display("FAIL %s_arm wr_reg=%b load_done=%b a=%h b=%h required 1 0 0 0",
                     tag, wr_reg, load_done, out_a, out_b);
        end
        for (int k = 0; k < NBEAT; k++) begin
            if (exp_q.size() > 0) pair = exp_q.pop_front();
            else pair = '0;
            {ea, eb} = pair;
            tick();
            checks++;
            if (out_a !== ea || out_b !== eb || wr_reg !== 1'b0 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL %s_beat%0d a=%h b=%h wr=%b done=%b required a=%h b=%h 0 0",
                         tag, k, out_a, out_b, wr_reg, load_done, ea, eb);
            end
            flush = (k == flush_at);
        end
        flush = 1'b0;
        tick();
        checks++;
        if (load_done !== 1'b1 || out_a !== '0 || out_b !== '0 || in_ready !== 1'b0 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done load_done=%b a=%h b=%h in_ready=%b busy=%b required 1 0 0 0 1",
                     tag, load_done, out_a, out_b, in_ready, busy);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || wr_reg !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle load_done=%b in_ready=%b busy=%b wr_reg=%b required 0 1 0 0",
                     tag, load_done, in_ready, busy, wr_reg);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        flush     = 1'b0;
        core_idle = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || wr_reg !== 1'b0 || load_done !== 1'b0 || busy !== 1'b0 ||
            out_a !== '0 || out_b !== '0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_vals in_ready=%b wr=%b done=%b busy=%b st=%0d required all 0",
                     in_ready, wr_reg, load_done, busy, dbg_state);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || wr_reg !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b busy=%b wr=%b required 1 0 0",
                     in_ready, busy, wr_reg);
        end
    endtask

    task automatic test_basic();
        core_idle = 1'b1;
        push_pair(DATA'(1), DATA'('h10));
        push_pair(DATA'(2), DATA'('h20));
        push_pair(DATA'(3), DATA'('h30));
        check_burst("basic", 0, -1);
    endtask

    task automatic test_core_busy();
        for (int i = 0; i < NBEAT; i++) push_pair(rand_word(), rand_word());
        check_burst("core_busy", 10, -1);
    endtask

    task automatic test_gaps();
        logic [5:0] pattern;
        pattern = 6'b101001;  // bit 0 first: 1,0,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            in_valid = pattern[i];
            in_a     = rand_word();
            in_b     = rand_word();
            if (pattern[i] && in_ready) exp_q.push_back({in_a, in_b});
            tick();
        end
        in_valid = 1'b0;
        check_burst("gaps", 0, -1);
    endtask

    task automatic test_flush_fill();
        push_pair(rand_word(), rand_word());
        push_pair(rand_word(), rand_word());
        // Flush with a simultaneous offered pair: both buffered and offered are discarded.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = rand_word();
        in_b     = rand_word();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL flush_fill busy=%b in_ready=%b st=%0d required 0 1 IDLE",
                     busy, in_ready, dbg_state);
        end
        for (int i = 0; i < NBEAT; i++) push_pair(rand_word(), rand_word());
        check_burst("after_flush", 0, -1);
    endtask

    task automatic test_flush_send();
        for (int i = 0; i < NBEAT; i++) push_pair(rand_word(), rand_word());
        check_burst("flush_send", 0, 1);
    endtask

    task automatic test_reset_mid();
        logic [DATA-1:0] ea;
        logic [DATA-1:0] eb;
        core_idle = 1'b1;
        for (int i = 0; i < NBEAT; i++) push_pair(rand_word(), rand_word());
        {ea, eb} = exp_q[1];
        tick();  // ARM
        tick();  // beat 0
        tick();  // beat 1
        checks++;
        if (out_a !== ea || out_b !== eb) begin
            errors++;
            $display("FAIL rst_mid_beat1 a=%h b=%h required a=%h b=%h", out_a, out_b, ea, eb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_reg !== 1'b0 || load_done !== 1'b0 || out_a !== '0 || out_b !== '0 ||
            busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async wr=%b done=%b a=%h b=%h busy=%b rdy=%b required all 0",
                     wr_reg, load_done, out_a, out_b, busy, in_ready);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE || wr_reg !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release rdy=%b busy=%b st=%0d wr=%b required 1 0 IDLE 0",
                     in_ready, busy, dbg_state, wr_reg);
        end
        // A fresh set of NBEAT pairs must form a full burst, proving the fill count restarted.
        for (int i = 0; i < NBEAT; i++) push_pair(rand_word(), rand_word());
        check_burst("after_rst", 0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NBEAT; i++) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                push_pair(rand_word(), rand_word());
            end
            check_burst("random", $urandom_range(0, 4), -1);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_basic();
        test_core_busy();
        test_gaps();
        test_flush_fill();
        test_flush_send();
        test_reset_mid();
        test_random();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
